// File: rtl/memory_read_server_pkg.sv
// ============================================================================
// memory_read_server_pkg : shared types and helpers for memory_read_server
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_read_server_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } mrs_state_t;

    function automatic int cnt_width(input int read_latency);
        return $clog2(read_latency + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin grant starting after last_grant
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] last_grant,
    output logic [NUM_PORTS-1:0]         grant,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         any_req
);

    localparam int c_idx_w = $clog2(NUM_PORTS);
    localparam logic [c_idx_w:0] c_num_ports = (c_idx_w + 1)'(NUM_PORTS);

    logic [c_idx_w:0] w_cand;
    logic             w_found;

    // Candidates are visited from last_grant+1 upward, wrapping modulo NUM_PORTS.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = {1'b0, last_grant} + (c_idx_w + 1)'(k);
            if (w_cand >= c_num_ports) begin
                w_cand = w_cand - c_num_ports;
            end
            if (!w_found && req[w_cand[c_idx_w-1:0]]) begin
                w_found                      = 1'b1;
                grant[w_cand[c_idx_w-1:0]]   = 1'b1;
                grant_idx                    = w_cand[c_idx_w-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/memory_read_server.sv
// ============================================================================
// memory_read_server : round-robin, coalescing read server for one sync RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_read_server
    import memory_read_server_pkg::*;
#(
    parameter int NUM_PORTS         = 4,
    parameter int MEMORY_ADDR_WIDTH = 10,
    parameter int MEMORY_WIDTH      = 40,
    parameter int READ_LATENCY      = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    input  logic [NUM_PORTS*MEMORY_ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_PORTS-1:0]                   req_ready,
    output logic [MEMORY_WIDTH-1:0]                req_data,
    output logic [MEMORY_ADDR_WIDTH-1:0]           broadcast_addr,
    output logic                                   broadcast_valid,
    output logic                                   mem_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]           mem_addr,
    input  logic [MEMORY_WIDTH-1:0]                mem_rdata
);

    localparam int c_idx_w = $clog2(NUM_PORTS);
    localparam int c_cnt_w = cnt_width(READ_LATENCY);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(READ_LATENCY - 1);

    mrs_state_t                    r_state;
    mrs_state_t                    w_next_state;
    logic [NUM_PORTS-1:0]          r_cur_sel;
    logic [c_idx_w-1:0]            r_last_grant;
    logic [MEMORY_ADDR_WIDTH-1:0]  r_cur_addr;
    logic [c_cnt_w-1:0]            r_cnt;
    logic [MEMORY_WIDTH-1:0]       r_data;

    logic [NUM_PORTS-1:0]          w_grant;
    logic [c_idx_w-1:0]            w_grant_idx;
    logic                          w_any_req;
    logic [MEMORY_ADDR_WIDTH-1:0]  w_grant_addr;
    logic [NUM_PORTS-1:0]          w_match;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .any_req    (w_any_req)
    );

    assign w_grant_addr = req_addr[w_grant_idx*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];

    // Waiting ports asking for the address being returned share this completion.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_coalesce
        assign w_match[g] = req_valid[g] &&
                            (req_addr[g*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH] == r_cur_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        mem_en          = 1'b0;
        req_ready       = '0;
        broadcast_valid = 1'b0;
        broadcast_addr  = '0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                mem_en       = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = RESPOND;
                end
            end
            RESPOND: begin
                req_ready       = r_cur_sel | w_match;
                broadcast_valid = 1'b1;
                broadcast_addr  = r_cur_addr;
                w_next_state    = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_sel    <= '0;
            r_last_grant <= c_idx_w'(NUM_PORTS - 1);
            r_cur_addr   <= '0;
            r_cnt        <= '0;
            r_data       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_cur_sel    <= w_grant;
                        r_last_grant <= w_grant_idx;
                        r_cur_addr   <= w_grant_addr;
                    end
                end
                ISSUE: r_cnt <= c_cnt_load;
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_data <= mem_rdata;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = r_cur_addr;
    assign req_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_memory_read_server.sv
// ============================================================================
// tb_memory_read_server : scoreboard bench for memory_read_server (latency 1 and 3)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_read_server;

    localparam int NP = 4;
    localparam int AW = 10;
    localparam int MW = 40;
    localparam logic [MW-1:0] GARB = 40'hEE_EEEE_EEEE;

    typedef struct {
        logic [NP-1:0] rdy;
        logic [MW-1:0] data;
        logic [AW-1:0] addr;
        int            at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NP-1:0]    req_valid, req_ready;
    logic [NP*AW-1:0] req_addr;
    logic [MW-1:0]    req_data, mem_rdata;
    logic [AW-1:0]    broadcast_addr, mem_addr;
    logic             broadcast_valid, mem_en;

    logic [NP-1:0]    req_valid_3, req_ready_3;
    logic [NP*AW-1:0] req_addr_3;
    logic [MW-1:0]    req_data_3, mem_rdata_3;
    logic [AW-1:0]    broadcast_addr_3, mem_addr_3;
    logic             broadcast_valid_3, mem_en_3;

    memory_read_server #(.NUM_PORTS(NP), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(MW), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .req_data(req_data), .broadcast_addr(broadcast_addr), .broadcast_valid(broadcast_valid),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata));

    memory_read_server #(.NUM_PORTS(NP), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(MW), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid_3), .req_addr(req_addr_3), .req_ready(req_ready_3),
        .req_data(req_data_3), .broadcast_addr(broadcast_addr_3), .broadcast_valid(broadcast_valid_3),
        .mem_en(mem_en_3), .mem_addr(mem_addr_3), .mem_rdata(mem_rdata_3));

    function automatic logic [MW-1:0] ram_word(input logic [AW-1:0] a);
        if (a == 10'h005) return 40'h12_3456_789A;
        return {a, ~a, 10'(a * 7 + 1), a ^ 10'h2AA};
    endfunction

    // RAM models: data is only meaningful exactly READ_LATENCY cycles after mem_en.
    logic [MW-1:0] p3 [3];
    always @(posedge clk) mem_rdata <= mem_en ? ram_word(mem_addr) : GARB;
    always @(posedge clk) begin
        p3[0] <= mem_en_3 ? ram_word(mem_addr_3) : GARB;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata_3 = p3[2];

    int men_cnt = 0, men_last = -1, men3_cnt = 0, men3_last = -1;
    always @(negedge clk) begin
        if (mem_en)   begin men_cnt  <= men_cnt + 1;  men_last  <= cyc; end
        if (mem_en_3) begin men3_cnt <= men3_cnt + 1; men3_last <= cyc; end
    end

    task automatic set_req(input int p, input logic [AW-1:0] a);
        req_valid[p] = 1'b1;
        req_addr[p*AW +: AW] = a;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit ok, output logic [NP-1:0] r,
                              output logic [MW-1:0] d, output logic [AW-1:0] ba,
                              output logic bv, output int at);
        ok = 1'b0; r = '0; d = '0; ba = '0; bv = 1'b0; at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready !== '0) begin
                ok = 1'b1; r = req_ready; d = req_data; ba = broadcast_addr; bv = broadcast_valid; at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else passes++;
        checks++; if (req_data !== '0) $display("FAIL reset_data: got %h want 0", req_data); else passes++;
        checks++; if (broadcast_valid !== 1'b0) $display("FAIL reset_bvalid: got %b want 0", broadcast_valid); else passes++;
        checks++; if (broadcast_addr !== '0) $display("FAIL reset_baddr: got %h want 0", broadcast_addr); else passes++;
        checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else passes++;
        checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passes++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int t, m0, at; bit ok; logic [NP-1:0] r; logic [MW-1:0] d; logic [AW-1:0] ba; logic bv; exp_t e;
        repeat (3) @(posedge clk);
        #1 t = cyc; m0 = men_cnt;
        set_req(1, 10'h005);
        sb.push_back('{4'b0010, 40'h12_3456_789A, 10'h005, t + 3});
        wait_ready(10, ok, r, d, ba, bv, at);
        e = sb.pop_front();
        checks++; if (!ok) $display("FAIL single_timeout: got none want ready"); else passes++;
        checks++; if (r !== e.rdy) $display("FAIL single_ready: got %b want %b", r, e.rdy); else passes++;
        checks++; if (d !== e.data) $display("FAIL single_data: got %h want %h", d, e.data); else passes++;
        checks++; if ({bv, ba} !== {1'b1, e.addr}) $display("FAIL single_bcast: got %b/%h want 1/%h", bv, ba, e.addr); else passes++;
        checks++; if (at !== e.at) $display("FAIL single_cycle: got %0d want %0d", at, e.at); else passes++;
        checks++; if (men_cnt - m0 !== 1) $display("FAIL single_mem_en_count: got %0d want 1", men_cnt - m0); else passes++;
        checks++; if (men_last !== t + 1) $display("FAIL single_mem_en_cycle: got %0d want %0d", men_last, t + 1); else passes++;
        @(posedge clk); #1 req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_data !== 40'h12_3456_789A) $display("FAIL single_hold: got %h want 123456789a", req_data); else passes++;
    endtask

    task automatic test_round_robin();
        int t, at; bit ok; logic [NP-1:0] r; logic [MW-1:0] d; logic [AW-1:0] ba; logic bv; exp_t e;
        logic [AW-1:0] addrs [NP];
        addrs = '{10'h010, 10'h021, 10'h032, 10'h043};
        do_reset();
        t = cyc;
        for (int p = 0; p < NP; p++) set_req(p, addrs[p]);
        for (int k = 0; k < 5; k++)
            sb.push_back('{4'b0001 << (k % NP), ram_word(addrs[k % NP]), addrs[k % NP], t + 3 + 4 * k});
        for (int k = 0; k < 5; k++) begin
            wait_ready(12, ok, r, d, ba, bv, at);
            e = sb.pop_front();
            checks++; if (!ok) $display("FAIL rr_timeout[%0d]: got none want ready", k); else passes++;
            checks++; if (r !== e.rdy) $display("FAIL rr_ready[%0d]: got %b want %b", k, r, e.rdy); else passes++;
            checks++; if (d !== e.data) $display("FAIL rr_data[%0d]: got %h want %h", k, d, e.data); else passes++;
            checks++; if (at !== e.at) $display("FAIL rr_cycle[%0d]: got %0d want %0d", k, at, e.at); else passes++;
        end
        @(posedge clk); #1 req_valid = '0;
    endtask

    task automatic test_coalesce();
        int t, m0, at; bit ok; logic [NP-1:0] r; logic [MW-1:0] d; logic [AW-1:0] ba; logic bv; exp_t e;
        do_reset();
        t = cyc; m0 = men_cnt;
        set_req(0, 10'h3FF); set_req(2, 10'h3FF); set_req(3, 10'h3FE);
        sb.push_back('{4'b0101, ram_word(10'h3FF), 10'h3FF, t + 3});
        sb.push_back('{4'b1000, ram_word(10'h3FE), 10'h3FE, t + 7});
        for (int k = 0; k < 2; k++) begin
            wait_ready(12, ok, r, d, ba, bv, at);
            e = sb.pop_front();
            checks++; if (!ok) $display("FAIL coal_timeout[%0d]: got none want ready", k); else passes++;
            checks++; if (r !== e.rdy) $display("FAIL coal_ready[%0d]: got %b want %b", k, r, e.rdy); else passes++;
            checks++; if (d !== e.data) $display("FAIL coal_data[%0d]: got %h want %h", k, d, e.data); else passes++;
            checks++; if ({bv, ba} !== {1'b1, e.addr}) $display("FAIL coal_bcast[%0d]: got %b/%h want 1/%h", k, bv, ba, e.addr); else passes++;
            checks++; if (at !== e.at) $display("FAIL coal_cycle[%0d]: got %0d want %0d", k, at, e.at); else passes++;
            checks++; if (men_cnt - m0 !== k + 1) $display("FAIL coal_mem_en[%0d]: got %0d want %0d", k, men_cnt - m0, k + 1); else passes++;
            @(posedge clk); #1 req_valid = req_valid & ~r;
        end
    endtask

    task automatic test_back_to_back();
        int t, at; bit ok; logic [NP-1:0] r; logic [MW-1:0] d; logic [AW-1:0] ba; logic bv; exp_t e;
        @(posedge clk); #1 t = cyc;
        set_req(1, 10'h050);
        sb.push_back('{4'b0010, ram_word(10'h050), 10'h050, t + 3});
        sb.push_back('{4'b0100, ram_word(10'h060), 10'h060, t + 7});
        repeat (3) @(posedge clk);
        #1 set_req(2, 10'h060);
        for (int k = 0; k < 2; k++) begin
            wait_ready(12, ok, r, d, ba, bv, at);
            e = sb.pop_front();
            checks++; if (!ok) $display("FAIL b2b_timeout[%0d]: got none want ready", k); else passes++;
            checks++; if (r !== e.rdy) $display("FAIL b2b_ready[%0d]: got %b want %b", k, r, e.rdy); else passes++;
            checks++; if (d !== e.data) $display("FAIL b2b_data[%0d]: got %h want %h", k, d, e.data); else passes++;
            checks++; if (at !== e.at) $display("FAIL b2b_cycle[%0d]: got %0d want %0d", k, at, e.at); else passes++;
            @(posedge clk); #1 req_valid = req_valid & ~r;
        end
    endtask

    task automatic test_reset_wait();
        int t, at; bit ok; logic [NP-1:0] r; logic [MW-1:0] d; logic [AW-1:0] ba; logic bv; exp_t e;
        // Serve port 0 first so that, without the reset, port 3 would win next.
        @(posedge clk); #1 t = cyc;
        set_req(0, 10'h100);
        wait_ready(12, ok, r, d, ba, bv, at);
        checks++; if (!ok || r !== 4'b0001) $display("FAIL rstw_pre: got %b want 0001", r); else passes++;
        @(posedge clk); #1 t = cyc;
        req_valid = '0;
        set_req(0, 10'h111); set_req(3, 10'h133);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0) $display("FAIL rstw_ready: got %b want 0", req_ready); else passes++;
        checks++; if (req_data !== '0) $display("FAIL rstw_data: got %h want 0", req_data); else passes++;
        checks++; if (broadcast_valid !== 1'b0) $display("FAIL rstw_bvalid: got %b want 0", broadcast_valid); else passes++;
        checks++; if (mem_en !== 1'b0) $display("FAIL rstw_mem_en: got %b want 0", mem_en); else passes++;
        checks++; if (mem_addr !== '0) $display("FAIL rstw_mem_addr: got %h want 0", mem_addr); else passes++;
        sb.push_back('{4'b0001, ram_word(10'h111), 10'h111, t + 6});
        sb.push_back('{4'b1000, ram_word(10'h133), 10'h133, t + 10});
        for (int k = 0; k < 2; k++) begin
            wait_ready(12, ok, r, d, ba, bv, at);
            e = sb.pop_front();
            checks++; if (!ok) $display("FAIL rstw_timeout[%0d]: got none want ready", k); else passes++;
            checks++; if (r !== e.rdy) $display("FAIL rstw_ready[%0d]: got %b want %b", k, r, e.rdy); else passes++;
            checks++; if (d !== e.data) $display("FAIL rstw_data[%0d]: got %h want %h", k, d, e.data); else passes++;
            checks++; if (at !== e.at) $display("FAIL rstw_cycle[%0d]: got %0d want %0d", k, at, e.at); else passes++;
            @(posedge clk); #1 req_valid = req_valid & ~r;
        end
    endtask

    task automatic test_latency3();
        int t, m0, at; bit ok; logic [NP-1:0] r; logic [MW-1:0] d; exp_t e;
        @(posedge clk); #1 t = cyc; m0 = men3_cnt;
        req_valid_3[2] = 1'b1;
        req_addr_3[2*AW +: AW] = 10'h0AB;
        sb.push_back('{4'b0100, ram_word(10'h0AB), 10'h0AB, t + 5});
        ok = 1'b0; r = '0; d = '0; at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready_3 !== '0) begin ok = 1'b1; r = req_ready_3; d = req_data_3; at = cyc; break; end
        end
        e = sb.pop_front();
        checks++; if (!ok) $display("FAIL lat3_timeout: got none want ready"); else passes++;
        checks++; if (r !== e.rdy) $display("FAIL lat3_ready: got %b want %b", r, e.rdy); else passes++;
        checks++; if (d !== e.data) $display("FAIL lat3_data: got %h want %h", d, e.data); else passes++;
        checks++; if (at !== e.at) $display("FAIL lat3_cycle: got %0d want %0d", at, e.at); else passes++;
        checks++; if (men3_last !== t + 1 || men3_cnt - m0 !== 1) $display("FAIL lat3_mem_en: got cycle %0d count %0d want %0d/1", men3_last, men3_cnt - m0, t + 1); else passes++;
        @(posedge clk); #1 req_valid_3 = '0;
    endtask

    initial begin
        req_valid = '0; req_addr = '0; req_valid_3 = '0; req_addr_3 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_coalesce();
        test_back_to_back();
        test_reset_wait();
        test_latency3();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
